// File: rtl/sseg_uart_scheduler.sv
// sseg_uart_scheduler
//   Shares one uart_tx byte stream (feeding a UART 7-segment display board)
//   between NREQ requesters. A round-robin arbiter picks one pending request,
//   its 4*NDISP-bit hex value is latched, then the FSM emits a clear character
//   (8'h80) followed by NDISP segment characters and pulses ack for that
//   requester.
//
//   Optional build macro SSEG_SCHED_LZ_BLANK_EN: leading-zero blanking. Zero
//   nibbles above the most-significant non-zero nibble go out as the blank
//   code; nibble 0 is never blanked.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req[NREQ]    per-requester request, held until its ack
//   data         NREQ packed 4*NDISP-bit values, requester r at [r*4*NDISP +: 4*NDISP]
//   ack[NREQ]    one-cycle pulse when the granted frame is complete
//   busy         high whenever the FSM is not idle
//   grant_idx    current / last granted requester
//   tx_data      registered character: bit 7 = CLR, bits 6:0 = segments
//   tx_valid     registered valid; transfer on tx_valid & tx_ready
//   tx_ready     uart_tx accept
module sseg_uart_scheduler #(
  parameter int NREQ       = 3,
  parameter int NDISP      = 6,
  parameter int HIGH_FIRST = 1,
  parameter int SEG_ON     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*4*NDISP-1:0]   data,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int DW = 4 * NDISP;
  localparam int IW = $clog2(NREQ);
  localparam int CW = (NDISP > 1) ? $clog2(NDISP) : 1;
  localparam logic [6:0] BLANK = (SEG_ON != 0) ? 7'h00 : 7'h7F;

  typedef enum logic [1:0] {IDLE, SEND_CLR, SEND_DIG, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      txd_q, txd_d;
  logic            txv_q, txv_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [NDISP-1:0] blank;
  logic             any_req;
  logic [IW-1:0]    gsel;
  logic             hs;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return (SEG_ON != 0) ? s : ~s;
  endfunction

  // Character for send slot c; the slot maps to a nibble by send order.
  function automatic logic [7:0] dig_char(input logic [DW-1:0] v,
                                          input logic [NDISP-1:0] bl,
                                          input int c);
    int k;
    k = (HIGH_FIRST != 0) ? (NDISP - 1 - c) : c;
    if (bl[k]) return {1'b0, BLANK};
    return {1'b0, seg_enc(v[4*k +: 4])};
  endfunction

`ifdef SSEG_SCHED_LZ_BLANK_EN
  // Walk down from the top nibble; a nibble is blank while every nibble at
  // or above it is zero. Nibble 0 always shows.
  always_comb begin
    logic zrun;
    zrun  = 1'b1;
    blank = '0;
    for (int k = NDISP - 1; k >= 0; k--) begin
      zrun     = zrun & (hold_q[4*k +: 4] == 4'h0);
      blank[k] = zrun & (k != 0);
    end
  end
`else
  assign blank = '0;
`endif

  // Round-robin pick: first set req at or above the pointer, with wrap.
  always_comb begin
    int idx;
    any_req = 1'b0;
    gsel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        gsel    = IW'(idx);
      end
    end
  end

  assign hs = txv_q & tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gidx_d  = gsel;
          hold_d  = data[int'(gsel)*DW +: DW];
          txd_d   = 8'h80;
          txv_d   = 1'b1;
          state_d = SEND_CLR;
        end
      end
      SEND_CLR: begin
        if (hs) begin
          cnt_d   = '0;
          txd_d   = dig_char(hold_q, blank, 0);
          state_d = SEND_DIG;
        end
      end
      SEND_DIG: begin
        if (hs) begin
          if (cnt_q == CW'(NDISP - 1)) begin
            txv_d         = 1'b0;
            ack_d[gidx_q] = 1'b1;   // ack_q is high during DONE
            state_d       = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            txd_d = dig_char(hold_q, blank, int'(cnt_q) + 1);
          end
        end
      end
      default: begin
        ptr_d   = IW'((int'(gidx_q) + 1) % NREQ);
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      ack_q   <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);
  assign grant_idx = gidx_q;
  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;

endmodule

// File: tb/tb_sseg_uart_scheduler.sv
// Bench for sseg_uart_scheduler: directed scenarios plus randomized frames,
// checked against a character/arbitration model computed from the display
// rules (nibble arithmetic, round-robin pointer).
module tb_sseg_uart_scheduler;
  localparam int NREQ  = 3;
  localparam int NDISP = 6;
  localparam int DW    = 4 * NDISP;
  localparam int SEG_ON = 0;
`ifdef SSEG_SCHED_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
  localparam int HF = 0;
`else
  localparam bit LZ = 1'b0;
  localparam int HF = 1;
`endif
  localparam logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic                   clk, rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*DW-1:0]     data;
  logic [NREQ-1:0]        ack;
  logic                   busy;
  logic [$clog2(NREQ)-1:0] grant_idx;
  logic [7:0]             tx_data;
  logic                   tx_valid, tx_ready;

  sseg_uart_scheduler #(.NREQ(NREQ), .NDISP(NDISP), .HIGH_FIRST(HF), .SEG_ON(SEG_ON)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack), .busy(busy),
    .grant_idx(grant_idx), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: character at frame position pos (0 = clear) for latched value v.
  function automatic logic [7:0] mchar(input logic [DW-1:0] v, input int pos);
    int i, n, top;
    logic [6:0] code;
    if (pos == 0) return 8'h80;
    i   = (HF != 0) ? (NDISP - pos) : (pos - 1);
    n   = int'((v >> (4 * i)) & 'hF);
    top = 0;
    for (int j = 0; j < NDISP; j++)
      if (((v >> (4 * j)) & 'hF) != 0) top = j;
    code = (LZ && i > top) ? 7'h00 : ENC[n];
    if (SEG_ON == 0) code = ~code;
    return {1'b0, code};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  logic [DW-1:0] exp_val [NREQ];
  int            mptr = 0;
  logic [7:0]    byteq[$], last_frame[$];
  int            ackq[$], ackcyc[$];
  int            busy_cnt = 0;
  logic          prev_v, prev_rdy;
  logic [7:0]    prev_d;
  logic [NREQ-1:0] prev_ack;

  // Monitor: collects transferred characters, checks hold-under-backpressure,
  // ack shape and each completed frame against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      byteq.delete();
      prev_v   = 1'b0;
      prev_rdy = 1'b1;
      prev_d   = '0;
      prev_ack = '0;
    end else begin
      if (prev_v && !prev_rdy) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_d);
      end
      if (busy) busy_cnt++;
      if (prev_ack != 0) chk("ack_width", ack, 0);
      if (ack != 0) begin
        chk("ack_onehot", $countones(ack), 1);
        for (int r = 0; r < NREQ; r++) begin
          if (ack[r]) begin
            ackq.push_back(r);
            ackcyc.push_back(cyc);
            chk("frame_len", byteq.size(), NDISP + 1);
            for (int p = 0; p < byteq.size() && p <= NDISP; p++)
              chk($sformatf("char%0d_r%0d", p, r), byteq[p], mchar(exp_val[r], p));
            last_frame = byteq;
            byteq.delete();
          end
        end
      end
      if (tx_valid && tx_ready) byteq.push_back(tx_data);
      prev_v   = tx_valid;
      prev_rdy = tx_ready;
      prev_d   = tx_data;
      prev_ack = ack;
    end
  end

  task automatic post(input int r, input logic [DW-1:0] v);
    exp_val[r]        = v;
    data[r*DW +: DW]  = v;
    req[r]            = 1'b1;
  endtask

  function automatic logic [DW-1:0] rv();
    logic [31:0] t;
    t = $urandom;
    return DW'(t >> $urandom_range(0, DW));
  endfunction

  // Runs one frame to its ack. wd: cycle (after entry) at which the granted
  // requester withdraws and scrambles its data; bp: stall 5 cycles on digit 3.
  task automatic run_frame(input int budget, input bit rnd, input int wd, input bit bp,
                           output int idx, output int acyc);
    int eg, n, bpl;
    bit bpd;
    logic [7:0] bref;
    eg = pick(req, mptr);
    idx = -1; acyc = 0; n = 0; bpl = 0; bpd = 1'b0; bref = '0;
    while (idx < 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (n == wd && eg >= 0) begin
        req[eg] = 1'b0;
        data[eg*DW +: DW] = ~exp_val[eg];
      end
      if (bpl > 0) tx_ready = 1'b0;
      else if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
      else tx_ready = 1'b1;
      @(negedge clk); #1;
      if (bpl > 0) begin
        chk("bp_valid", tx_valid, 1);
        chk("bp_data", tx_data, bref);
        bpl--;
      end
      if (bp && !bpd && eg >= 0 && byteq.size() == 3) begin
        bpd  = 1'b1;
        bpl  = 5;
        bref = mchar(exp_val[eg], 3);
      end
      if (ackq.size() > 0) begin
        idx  = ackq.pop_front();
        acyc = ackcyc.pop_front();
      end
    end
    if (idx < 0) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    chk("grant", idx, eg);
    chk("grant_idx", grant_idx, eg);
    mptr = (idx + 1) % NREQ;
    @(posedge clk); #1;
    req[idx] = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mptr = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int idx, acyc, rcyc, n;
    logic [7:0] exp_f [7];
    rst_n = 1'b0; req = '0; data = '1; tx_ready = 1'b1;
    for (int r = 0; r < NREQ; r++) exp_val[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gidx", grant_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single uncontended frame: latency and busy length.
`ifdef SSEG_SCHED_LZ_BLANK_EN
    post(1, 24'h000050);
`else
    post(1, 24'h12AB3F);
`endif
    rcyc = cyc; busy_cnt = 0;
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    chk("ack_latency_incl", acyc - rcyc + 1, NDISP + 3);
    chk("busy_cycles", busy_cnt, NDISP + 2);
`ifdef SSEG_SCHED_LZ_BLANK_EN
    exp_f = '{8'h80, 8'h40, 8'h12, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
`else
    exp_f = '{8'h80, 8'h79, 8'h24, 8'h08, 8'h03, 8'h30, 8'h0E};
`endif
    for (int p = 0; p < 7; p++)
      chk($sformatf("single_b%0d", p), (p < last_frame.size()) ? last_frame[p] : 8'hXX, exp_f[p]);
`ifdef SSEG_SCHED_LZ_BLANK_EN
    post(1, 24'h000000);
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    exp_f = '{8'h80, 8'h40, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    for (int p = 0; p < 7; p++)
      chk($sformatf("zero_b%0d", p), (p < last_frame.size()) ? last_frame[p] : 8'hXX, exp_f[p]);
`endif

    // Round robin after reset: 0 and 2 together, 0 re-posted after its ack.
    do_reset();
    post(0, rv()); post(2, rv());
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    chk("rr_first", idx, 0);
    post(0, rv());
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    chk("rr_second", idx, 2);
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    chk("rr_third", idx, 0);

    // Backpressure on the third digit.
    post(1, rv());
    run_frame(100, 1'b0, -1, 1'b1, idx, acyc);

    // Withdrawal: req[2] drops and data[2] changes after grant.
    post(2, 24'hC0FFEE);
    run_frame(100, 1'b0, 3, 1'b0, idx, acyc);
    chk("withdraw_ack", idx, 2);

    // Reset mid-frame; pointer returns to 0 so req[1] beats pending req[2].
    post(1, rv());
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);   // pointer now 2
    post(2, rv());
    n = 0;
    while (byteq.size() != 3 && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      n++;
    end
    chk("mid_reached", byteq.size(), 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", tx_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ack", ack, 0);
    mptr = 0;
    post(1, rv());
    repeat (3) @(posedge clk);
    #1;
    chk("mid_noack", ackq.size(), 0);
    rst_n = 1'b1;
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    chk("post_rst_win", idx, 1);
    run_frame(100, 1'b0, -1, 1'b0, idx, acyc);
    chk("post_rst_next", idx, 2);

    // Randomized traffic with random tx_ready.
    for (int f = 0; f < 40; f++) begin
      for (int r = 0; r < NREQ; r++)
        if (!req[r] && $urandom_range(0, 1) == 1) post(r, rv());
      if (req == '0) post($urandom_range(0, NREQ - 1), rv());
      run_frame(400, 1'b1, -1, 1'b0, idx, acyc);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
